// File: rtl/rx_serial_pkg.sv
// Shared definitions for the 7O1 serial receiver: state codes, frame geometry
// and the parity-error rule.
package rx_serial_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_START  = 4'd1,
    ST_DATA   = 4'd2,
    ST_PARITY = 4'd3,
    ST_STOP   = 4'd4,
    ST_DONE   = 4'd5
  } state_t;

  localparam int N_DATA_BITS = 7;
  localparam int FRAME_BITS  = 10;

  // Odd parity: the frame is bad when data plus parity hold an even number of ones.
  function automatic logic paridade_erro(input logic [N_DATA_BITS-1:0] dados,
                                         input logic paridade);
    return ~((^dados) ^ paridade);
  endfunction

endpackage

// File: rtl/rx_serial_7o1_contador_baud.sv
// Loadable baud down-counter; fim flags the sample instant (count == 0).
module contador_baud
  import rx_serial_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             carrega,
  input  logic [WIDTH-1:0] valor,
  output logic             fim
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Load has priority; otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (carrega) begin
      cnt_d = valor;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign fim = (cnt_q == '0);

endmodule

// File: rtl/rx_serial_7o1.sv
// 7O1 serial receiver: 1 start, 7 data LSB-first, odd parity, 1 stop.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | half-bit wait, re-check start bit (reject glitches)
// DATA   | sample 7 data bits at bit centres
// PARITY | sample parity bit
// STOP   | sample stop bit
// DONE   | one cycle: publish data, flags and pronto
module rx_serial_7o1
  import rx_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  input  logic       recebe_dado,
  output logic [6:0] dados_ascii,
  output logic       pronto,
  output logic       tem_dado,
  output logic       erro_paridade,
  output logic       erro_stop,
  output logic       erro_overrun,
  output logic [3:0] db_estado
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LOAD_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] LOAD_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(N_DATA_BITS - 1);

  state_t                 state_q, state_d;
  logic [1:0]             sync_q;
  logic                   rx_s;
  logic                   fim;
  logic                   carrega;
  logic [CNT_W-1:0]       carga_val;
  logic [2:0]             bit_idx_q;
  logic [N_DATA_BITS-1:0] shift_q;
  logic                   par_q, stop_q;
  logic [N_DATA_BITS-1:0] dados_q;
  logic                   tem_q, erro_par_q, erro_stop_q, ovr_q;

  // Two-flop synchronizer, preset to the idle-high line level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], entrada_serial};
  end

  assign rx_s = sync_q[1];

  contador_baud #(.WIDTH(CNT_W)) u_contador_baud (
    .clock   (clock),
    .reset   (reset),
    .carrega (carrega),
    .valor   (carga_val),
    .fim     (fim)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; every bit-period move waits for the baud counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!rx_s) state_d = ST_START;
      ST_START:  if (fim) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (fim && (bit_idx_q == LAST_BIT)) state_d = ST_PARITY;
      ST_PARITY: if (fim) state_d = ST_STOP;
      ST_STOP:   if (fim) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: baud counter reloads and the completion pulse.
  always_comb begin
    carrega   = 1'b0;
    carga_val = LOAD_BIT;
    pronto    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        carrega   = !rx_s;
        carga_val = LOAD_HALF;
      end
      ST_START:  carrega = fim && !rx_s;
      ST_DATA:   carrega = fim;
      ST_PARITY: carrega = fim;
      ST_DONE:   pronto  = 1'b1;
      default: ;
    endcase
  end

  // Bit capture at each sample instant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      stop_q    <= 1'b1;
    end else if (fim) begin
      case (state_q)
        ST_START: bit_idx_q <= '0;
        ST_DATA: begin
          shift_q[bit_idx_q] <= rx_s;
          bit_idx_q          <= bit_idx_q + 3'd1;
        end
        ST_PARITY: par_q  <= rx_s;
        ST_STOP:   stop_q <= rx_s;
        default: ;
      endcase
    end
  end

  // Published character and flags; frame completion beats an acknowledge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dados_q     <= '0;
      tem_q       <= 1'b0;
      erro_par_q  <= 1'b0;
      erro_stop_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else if (state_q == ST_DONE) begin
      dados_q     <= shift_q;
      erro_par_q  <= paridade_erro(shift_q, par_q);
      erro_stop_q <= ~stop_q;
      ovr_q       <= tem_q;
      tem_q       <= 1'b1;
    end else if (recebe_dado && tem_q) begin
      tem_q <= 1'b0;
      ovr_q <= 1'b0;
    end
  end

  assign dados_ascii   = dados_q;
  assign tem_dado      = tem_q;
  assign erro_paridade = erro_par_q;
  assign erro_stop     = erro_stop_q;
  assign erro_overrun  = ovr_q;
  assign db_estado     = state_q;

endmodule

// File: tb/tb_rx_serial_7o1.sv
// Bench for rx_serial_7o1: directed frames, a frame-level scoreboard model and
// a per-cycle compare of every output against it.
module tb_rx_serial_7o1;

  localparam int CPB = 16;
  localparam int HB  = CPB / 2;
  localparam int LAT = 2 + HB + 9 * CPB + 1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       entrada_serial = 1'b1;
  logic       recebe_dado = 1'b0;
  logic [6:0] dados_ascii;
  logic       pronto, tem_dado, erro_paridade, erro_stop, erro_overrun;
  logic [3:0] db_estado;

  always #5 clock = ~clock;

  rx_serial_7o1 #(.CLKS_PER_BIT(CPB)) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .recebe_dado    (recebe_dado),
    .dados_ascii    (dados_ascii),
    .pronto         (pronto),
    .tem_dado       (tem_dado),
    .erro_paridade  (erro_paridade),
    .erro_stop      (erro_stop),
    .erro_overrun   (erro_overrun),
    .db_estado      (db_estado)
  );

  typedef struct {
    logic [6:0] data;
    logic       perr;
    logic       serr;
    int         t0;
  } frame_t;

  frame_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_pronto = 0;

  // Model state: what the outputs must show after the frames seen so far.
  logic [6:0] m_dados = '0;
  logic m_tem = 0, m_perr = 0, m_serr = 0, m_ovr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare: advance the model on each edge, then check the DUT.
  initial begin : compare
    frame_t pend;
    bit have_pend;
    have_pend = 0;
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      if (!reset) begin
        m_dados = '0; m_tem = 0; m_perr = 0; m_serr = 0; m_ovr = 0;
        have_pend = 0;
      end else if (have_pend) begin
        m_dados = pend.data;
        m_perr  = pend.perr;
        m_serr  = pend.serr;
        m_ovr   = m_tem;
        m_tem   = 1'b1;
        have_pend = 0;
      end else if (recebe_dado && m_tem) begin
        m_tem = 1'b0;
        m_ovr = 1'b0;
      end
      if (pronto) begin
        n_pronto++;
        chk("pronto_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          pend = sb.pop_front();
          have_pend = 1;
          chk("pronto_latency", (cyc - pend.t0 >= LAT - 1) && (cyc - pend.t0 <= LAT + 1), 1);
        end
      end
      chk("dados_ascii", dados_ascii, m_dados);
      chk("tem_dado", tem_dado, m_tem);
      chk("erro_paridade", erro_paridade, m_perr);
      chk("erro_stop", erro_stop, m_serr);
      chk("erro_overrun", erro_overrun, m_ovr);
      if (!reset) begin
        chk("pronto_in_reset", pronto, 0);
        chk("db_estado_in_reset", db_estado, 0);
      end
    end
  end

  // Drive one frame and push its expected result; the line is left at the stop level.
  task automatic send_frame(input logic [6:0] ch, input logic par, input logic stp);
    frame_t f;
    f.data = ch;
    f.perr = ~((^ch) ^ par);
    f.serr = ~stp;
    f.t0   = cyc;
    sb.push_back(f);
    entrada_serial = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 7; i++) begin
      entrada_serial = ch[i];
      repeat (CPB) @(negedge clock);
    end
    entrada_serial = par;
    repeat (CPB) @(negedge clock);
    entrada_serial = stp;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic idle(input int n);
    entrada_serial = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic ack();
    recebe_dado = 1'b1;
    @(negedge clock);
    recebe_dado = 1'b0;
  endtask

  task automatic wait_delivered();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("frame_delivered", sb.size(), 0);
  endtask

  function automatic logic odd_par(input logic [6:0] ch);
    return ~(^ch);
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int p0;
    bit seen_start;
    // Reset held with the line toggling.
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      entrada_serial = ~entrada_serial;
      @(negedge clock);
    end
    chk("reset_db_estado", db_estado, 0);
    chk("reset_dados", dados_ascii, 0);
    chk("reset_tem", tem_dado, 0);
    reset = 1'b1;
    p0 = n_pronto;
    idle(40);
    chk("idle_no_pronto", n_pronto - p0, 0);
    chk("idle_db_estado", db_estado, 0);

    // '#' with correct parity.
    send_frame(7'h23, 1'b0, 1'b1);
    idle(4);
    wait_delivered();
    chk("hash_dados", dados_ascii, 7'h23);
    chk("hash_tem", tem_dado, 1);
    chk("hash_perr", erro_paridade, 0);
    chk("hash_serr", erro_stop, 0);
    chk("hash_ovr", erro_overrun, 0);
    ack();
    chk("hash_ack_tem", tem_dado, 0);

    // '5' with wrong parity, then '0' with correct parity.
    send_frame(7'h35, 1'b0, 1'b1);
    idle(4);
    wait_delivered();
    chk("five_dados", dados_ascii, 7'h35);
    chk("five_perr", erro_paridade, 1);
    send_frame(7'h30, 1'b1, 1'b1);
    idle(4);
    wait_delivered();
    chk("zero_dados", dados_ascii, 7'h30);
    chk("zero_perr", erro_paridade, 0);
    chk("zero_ovr", erro_overrun, 1);
    ack();

    // '7' with a low stop bit.
    p0 = n_pronto;
    send_frame(7'h37, odd_par(7'h37), 1'b0);
    idle(40);
    wait_delivered();
    chk("seven_dados", dados_ascii, 7'h37);
    chk("seven_serr", erro_stop, 1);
    chk("seven_perr", erro_paridade, 0);
    chk("seven_one_pronto", n_pronto - p0, 1);
    ack();

    // 4-cycle glitch on an idle line.
    p0 = n_pronto;
    seen_start = 0;
    entrada_serial = 1'b0;
    repeat (4) @(negedge clock);
    entrada_serial = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (db_estado == 4'd1) seen_start = 1;
      @(negedge clock);
    end
    chk("glitch_saw_start", seen_start, 1);
    chk("glitch_back_idle", db_estado, 0);
    chk("glitch_no_pronto", n_pronto - p0, 0);
    chk("glitch_dados_kept", dados_ascii, 7'h37);

    // Back-to-back "4","2","1","#" without acknowledge.
    p0 = n_pronto;
    send_frame(7'h34, odd_par(7'h34), 1'b1);
    send_frame(7'h32, odd_par(7'h32), 1'b1);
    send_frame(7'h31, odd_par(7'h31), 1'b1);
    send_frame(7'h23, odd_par(7'h23), 1'b1);
    idle(10);
    wait_delivered();
    chk("b2b_pronto_count", n_pronto - p0, 4);
    chk("b2b_dados", dados_ascii, 7'h23);
    chk("b2b_ovr", erro_overrun, 1);
    chk("b2b_tem", tem_dado, 1);
    ack();
    chk("b2b_ack_tem", tem_dado, 0);
    chk("b2b_ack_ovr", erro_overrun, 0);

    idle(5);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_serial_7o1.md
Name: rx_serial_7O1

Overview:
- Asynchronous serial receiver for the 7O1 frame format: 1 start bit, 7 data bits LSB-first, odd parity, 1 stop bit.
- It is the downstream consumer of the serial transmit datapath's saida_serial line. It recovers each ASCII character: BCD digits '0'-'9' and the '#' separator.
- Each received character is presented to the consuming logic with a ready pulse, a held-data flag and error flags.
- It also serves as the loopback checker for the transmit path.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per bit (50 MHz / 115200 baud); must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2: cycles from a detected start edge to the start-bit mid-sample.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset), released synchronously to clock.
- entrada_serial  in  1  serial line; idle high; asynchronous to clock.
- recebe_dado  in  1  consumer acknowledge; a 1-cycle pulse clears tem_dado.
- dados_ascii  out  7  last received character; held until the next frame completes.
- pronto  out  1  1-cycle pulse on frame completion.
- tem_dado  out  1  level: an unacknowledged character is held.
- erro_paridade  out  1  parity check of the last frame failed.
- erro_stop  out  1  stop bit of the last frame sampled low (framing error).
- erro_overrun  out  1  a frame completed while tem_dado was already 1.
- db_estado  out  4  current FSM state code, for debug.

Behaviour:
- Reset (reset=0), forced immediately and asynchronously:
  - FSM goes to IDLE; bit and baud counters go to 0.
  - dados_ascii=0; pronto=0; tem_dado=0; all error flags=0.
  - Synchronizer flops preset to 1 (line idle).
- Input path: entrada_serial passes through 2 synchronizer flops. All sampling uses the synchronized value (rx_s).
- FSM states and db_estado codes:
  - IDLE=0: wait for rx_s=0, then load the baud counter with HALF_BIT-1 and go to START.
  - START=1: on counter expiry re-check rx_s.
    - rx_s=1 (glitch): return to IDLE; no outputs change.
    - rx_s=0: reload CLKS_PER_BIT-1, clear the bit index, go to DATA.
  - DATA=2: on each expiry shift rx_s into shift register bit [index] (LSB first) and reload. After index 6, go to PARITY.
  - PARITY=3: on expiry capture the parity bit and reload; go to STOP.
  - STOP=4: on expiry sample the stop bit; go to DONE.
  - DONE=5: one cycle long; updates the outputs (next item), then returns to IDLE.
- DONE-cycle updates:
  - dados_ascii <= shift register.
  - erro_paridade <= (XOR of 7 data bits ^ parity bit) == 0, i.e. set when the total count of ones is even.
  - erro_stop <= ~stop sample.
  - erro_overrun <= tem_dado.
  - tem_dado <= 1; pronto=1 for exactly this cycle.
- Framing and parity errors do not suppress delivery: data, pronto and tem_dado update regardless. Error flags are re-evaluated every frame.
- Timing:
  - IDLE accepts a new start edge on the cycle after DONE, so back-to-back frames with a 1-bit stop are supported.
  - Latency from an entrada_serial falling edge to pronto is 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles (±1).
- recebe_dado:
  - Clears tem_dado and erro_overrun on the next edge.
  - If it coincides with DONE, DONE wins: tem_dado=1 and erro_overrun=1.
  - Ignored when tem_dado=0.
- entrada_serial stuck low: after a framing error the FSM waits in IDLE and re-triggers on the still-low line. This behaviour is accepted.
- Reset mid-frame abandons the frame. No pronto is issued. dados_ascii returns to 0.

Decomposition:
- Package rx_serial_pkg:
  - state encodings (IDLE..DONE, 4-bit);
  - N_DATA_BITS=7; frame length 10.
- Sub-module contador_baud: loadable down-counter with terminal-count output, parameter width = clog2(CLKS_PER_BIT).
  - It supplies every sample instant.
  - It is the only counter besides the 3-bit bit index.

Test Plan (all scenarios use CLKS_PER_BIT=16):
- Reset: hold reset=0 with the line toggling -> all outputs 0 and db_estado=0; after release and 40 idle-high cycles, still no pronto.
- '#' (0x23): data bits 1,1,0,0,0,1,0, parity 0, stop 1 -> one pronto pulse; dados_ascii=7'h23; tem_dado=1; all errors 0.
- '5' (0x35) sent with parity 0 (wrong) -> dados_ascii=7'h35; erro_paridade=1. Next correct frame '0' (0x30, parity 1) -> erro_paridade=0.
- Stop bit driven 0 on '7' (0x37) -> dados_ascii=7'h37; erro_stop=1; pronto pulses once.
- 4-cycle low glitch on an idle line -> FSM returns to IDLE from START; no pronto; dados_ascii unchanged.
- Back-to-back "4","2","1","#" with no acknowledge -> four pronto pulses; final dados_ascii=7'h23; erro_overrun=1. Pulse recebe_dado -> tem_dado=0 and erro_overrun=0 on the next cycle.
